clb_cfg: RTL and testbench

Parametrised, serially configured logic block: `N_SLICE` slices, each a `LUT_K`-input lookup table feeding one D flip-flop with clock enable, synchronous set/reset value, optional Q feedback into the LUT and a comb/registered output select. Configuration is shifted in over a daisy-chainable serial port rather than fixed at elaboration, and the block can be reconfigured at run time. It is the next-generation tile for the FPGA fabric array and is chained through `CFG_DOUT`.

---
 rtl/clb_cfg_pkg.sv | 24 ++
 rtl/clb_slice.sv | 71 +++++++
 rtl/clb_cfg.sv | 105 ++++++++++
 tb/tb_clb_cfg.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clb_cfg_pkg.sv
// clb_cfg_pkg: shared types and frame layout for the serially configured logic block.
package clb_cfg_pkg;

    // Configuration state of a block.
    typedef enum logic [1:0] {
        ST_UNCONF  = 2'd0,
        ST_LOADING = 2'd1,
        ST_RUN     = 2'd2
    } cfg_state_e;

    // Control field offsets, counted from the end of the truth table in a slice frame.
    localparam int OFF_OUTSEL = 0;
    localparam int OFF_FB     = 1;
    localparam int OFF_CEUSE  = 2;
    localparam int OFF_SRVAL  = 3;
    localparam int OFF_INIT   = 4;
    localparam int OFF_BYP    = 5;

    // Bits per slice frame: full truth table plus six control bits.
    function automatic int cfg_w(input int lut_k);
        return (1 << lut_k) + 6;
    endfunction

endpackage

// File: rtl/clb_slice.sv
// clb_slice: one LUT, D-input mux, flop with CE/SR, and comb/registered output select.
module clb_slice
    import clb_cfg_pkg::*;
#(
    parameter int LUT_K = 4,
    parameter int CFG_W = cfg_w(LUT_K)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             stay_run,
    input  logic             enter,
    input  logic             init_new,
    input  logic [CFG_W-1:0] cfg,
    input  logic [LUT_K-1:0] lut_in,
    input  logic             ce,
    input  logic             sr,
    output logic             o,
    output logic             x
);

    localparam int TBL = 2**LUT_K;

    logic [TBL-1:0]   tbl;
    logic [LUT_K-1:0] lut_idx;
    logic             lut_out;
    logic             d;
    logic             q_q;
    logic             q_d;

    assign tbl = cfg[TBL-1:0];

    // LUT lookup; with feedback the top LUT input comes from Q so the loop is always registered.
    always_comb begin
        lut_idx = lut_in;
        if (cfg[TBL+OFF_FB]) begin
            lut_idx[LUT_K-1] = q_q;
        end
        lut_out = tbl[lut_idx];
        d       = cfg[TBL+OFF_BYP] ? lut_in[0] : lut_out;
    end

    // Next Q: INIT on entry to RUN, SR over CE while running, otherwise held at zero.
    always_comb begin
        q_d = 1'b0;
        if (enter) begin
            q_d = init_new;
        end else if (stay_run) begin
            if (sr) begin
                q_d = cfg[TBL+OFF_SRVAL];
            end else if (!cfg[TBL+OFF_CEUSE] || ce) begin
                q_d = d;
            end else begin
                q_d = q_q;
            end
        end
    end

    // Slice flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign o = run & lut_out;
    assign x = run & (cfg[TBL+OFF_OUTSEL] ? q_q : lut_out);

endmodule

// File: rtl/clb_cfg.sv
// clb_cfg: logic block with a daisy-chainable serial configuration chain and N_SLICE slices.
module clb_cfg
    import clb_cfg_pkg::*;
#(
    parameter int LUT_K   = 4,
    parameter int N_SLICE = 2
) (
    input  logic                       K,
    input  logic                       RST,
    input  logic                       CFG_EN,
    input  logic                       CFG_DIN,
    output logic                       CFG_DOUT,
    output logic                       CFG_DONE,
    input  logic [N_SLICE*LUT_K-1:0]   I,
    input  logic [N_SLICE-1:0]         CE,
    input  logic [N_SLICE-1:0]         SR,
    output logic [N_SLICE-1:0]         O,
    output logic [N_SLICE-1:0]         X
);

    localparam int CFG_W   = cfg_w(LUT_K);
    localparam int CFG_LEN = N_SLICE * CFG_W;
    localparam int TBL     = 2**LUT_K;
    localparam int CNT_W   = $clog2(CFG_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_LEN - 1);

    cfg_state_e         state_q;
    cfg_state_e         state_d;
    logic [CFG_LEN-1:0] chain_q;
    logic [CFG_LEN-1:0] chain_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               run;
    logic               stay_run;
    logic               enter;

    // State, configuration chain and bit counter registers.
    always_ff @(posedge K or posedge RST) begin
        if (RST) begin
            state_q <= ST_UNCONF;
            chain_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            chain_q <= chain_d;
            count_q <= count_d;
        end
    end

    // Next state: every enabled edge shifts one bit; the last bit of a frame moves to RUN.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        chain_d = chain_q;
        if (CFG_EN) begin
            chain_d = {CFG_DIN, chain_q[CFG_LEN-1:1]};
            case (state_q)
                ST_LOADING: begin
                    if (count_q == CNT_LAST) begin
                        state_d = ST_RUN;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_LOADING;
                    count_d = CNT_ONE;
                end
            endcase
        end
    end

    // Decoded controls for the slices and the done flag.
    always_comb begin
        run      = (state_q == ST_RUN);
        stay_run = run && !CFG_EN;
        enter    = (state_q == ST_LOADING) && CFG_EN && (count_q == CNT_LAST);
        CFG_DONE = run;
    end

    assign CFG_DOUT = chain_q[0];

    for (genvar s = 0; s < N_SLICE; s++) begin : g_slice
        clb_slice #(
            .LUT_K (LUT_K),
            .CFG_W (CFG_W)
        ) u_slice (
            .clk      (K),
            .rst      (RST),
            .run      (run),
            .stay_run (stay_run),
            .enter    (enter),
            .init_new (chain_d[s*CFG_W + TBL + OFF_INIT]),
            .cfg      (chain_q[s*CFG_W +: CFG_W]),
            .lut_in   (I[s*LUT_K +: LUT_K]),
            .ce       (CE[s]),
            .sr       (SR[s]),
            .o        (O[s]),
            .x        (X[s])
        );
    end

endmodule

// File: tb/tb_clb_cfg.sv
// tb_clb_cfg: randomized scoreboard bench for clb_cfg against a frame-level reference model.
module tb_clb_cfg;

    localparam int LUT_K   = 4;
    localparam int N_SLICE = 2;
    localparam int TBL     = 1 << LUT_K;
    localparam int CFG_W   = TBL + 6;
    localparam int CFG_LEN = N_SLICE * CFG_W;

    logic                     K = 1'b0;
    logic                     RST;
    logic                     CFG_EN;
    logic                     CFG_DIN;
    logic                     CFG_DOUT;
    logic                     CFG_DONE;
    logic [N_SLICE*LUT_K-1:0] I;
    logic [N_SLICE-1:0]       CE;
    logic [N_SLICE-1:0]       SR;
    logic [N_SLICE-1:0]       O;
    logic [N_SLICE-1:0]       X;

    typedef struct {
        logic               done;
        logic               dout;
        logic [N_SLICE-1:0] o;
        logic [N_SLICE-1:0] x;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: last CFG_LEN bits received, bits of the load in progress, run flag, Q per slice.
    bit   hist[$];
    int   pending;
    bit   running;
    bit   mq[N_SLICE];

    clb_cfg #(.LUT_K(LUT_K), .N_SLICE(N_SLICE)) dut (
        .K        (K),
        .RST      (RST),
        .CFG_EN   (CFG_EN),
        .CFG_DIN  (CFG_DIN),
        .CFG_DOUT (CFG_DOUT),
        .CFG_DONE (CFG_DONE),
        .I        (I),
        .CE       (CE),
        .SR       (SR),
        .O        (O),
        .X        (X)
    );

    always #5 K = ~K;

    // Bit j of the configured chain: the bit received CFG_LEN-1-j shifts before the newest one.
    function automatic bit chain_bit(input int j);
        int idx;
        idx = hist.size() - CFG_LEN + j;
        if (idx < 0) return 1'b0;
        return hist[idx];
    endfunction

    function automatic bit field(input int s, input int off);
        return chain_bit(s * CFG_W + off);
    endfunction

    function automatic bit lut_value(input int s);
        int idx;
        idx = int'(I[s*LUT_K +: LUT_K]);
        if (field(s, TBL + 1)) idx = (idx % (TBL / 2)) + (mq[s] ? TBL / 2 : 0);
        return field(s, idx);
    endfunction

    function automatic exp_t predict();
        exp_t e;
        e.done = running;
        e.dout = chain_bit(0);
        e.o    = '0;
        e.x    = '0;
        if (running) begin
            for (int s = 0; s < N_SLICE; s++) begin
                e.o[s] = lut_value(s);
                e.x[s] = field(s, TBL + 0) ? mq[s] : e.o[s];
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        hist.delete();
        pending = 0;
        running = 1'b0;
        for (int s = 0; s < N_SLICE; s++) mq[s] = 1'b0;
    endtask

    task automatic model_edge();
        bit d[N_SLICE];
        if (RST) begin
            model_reset();
            return;
        end
        for (int s = 0; s < N_SLICE; s++) begin
            d[s] = field(s, TBL + 5) ? I[s*LUT_K] : lut_value(s);
        end
        if (CFG_EN) begin
            hist.push_back(CFG_DIN);
            if (hist.size() > CFG_LEN) void'(hist.pop_front());
            pending++;
            running = 1'b0;
            if (pending == CFG_LEN) begin
                running = 1'b1;
                pending = 0;
            end
            for (int s = 0; s < N_SLICE; s++) mq[s] = running ? field(s, TBL + 4) : 1'b0;
        end else if (running) begin
            for (int s = 0; s < N_SLICE; s++) begin
                if (SR[s]) mq[s] = field(s, TBL + 3);
                else if (!field(s, TBL + 2) || CE[s]) mq[s] = d[s];
            end
        end else begin
            for (int s = 0; s < N_SLICE; s++) mq[s] = 1'b0;
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock: drive inputs just after the edge, queue the expectation, advance the model on the edge.
    task automatic apply_stimulus(input bit rst, input bit en, input bit din);
        RST     = rst;
        CFG_EN  = en;
        CFG_DIN = din;
        I       = (N_SLICE*LUT_K)'($urandom);
        if ($urandom_range(3) == 0) I[LUT_K-1:0] = '1;
        CE      = N_SLICE'($urandom);
        SR      = ($urandom_range(3) == 0) ? N_SLICE'($urandom) : '0;
        if (rst) model_reset();
        exp_q.push_back(predict());
        @(posedge K);
        model_edge();
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) apply_stimulus(1'b0, 1'b0, 1'($urandom));
    endtask

    task automatic send_bits(input logic [CFG_LEN-1:0] frame, input int lo, input int hi, input int pause_pct);
        for (int j = lo; j < hi; j++) begin
            while (int'($urandom_range(99)) < pause_pct) apply_stimulus(1'b0, 1'b0, 1'($urandom));
            apply_stimulus(1'b0, 1'b1, frame[j]);
        end
    endtask

    function automatic logic [CFG_W-1:0] mk_slice(input logic [TBL-1:0] tbl, input bit outsel, input bit fb,
                                                 input bit ceuse, input bit srval, input bit init, input bit byp);
        return {byp, init, srval, ceuse, fb, outsel, tbl};
    endfunction

    function automatic logic [CFG_W-1:0] rand_slice();
        return CFG_W'({$urandom, $urandom});
    endfunction

    // Monitor: compare every DUT output against the oldest queued expectation.
    always @(negedge K) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("cfg_done", 32'(CFG_DONE), 32'(e.done));
            check_output("cfg_dout", 32'(CFG_DOUT), 32'(e.dout));
            check_output("o_out",    32'(O),        32'(e.o));
            check_output("x_out",    32'(X),        32'(e.x));
        end
    end

    initial begin
        logic [CFG_LEN-1:0] fa;
        logic [CFG_LEN-1:0] fb;
        RST = 1'b1; CFG_EN = 1'b0; CFG_DIN = 1'b0; I = '0; CE = '0; SR = '0;
        model_reset();
        @(posedge K);
        #1;
        for (int c = 0; c < 3; c++) apply_stimulus(1'b1, 1'b0, 1'b0);
        run_cycles(3);

        // AND4 in slice 0, combinational output.
        fa = {rand_slice(), mk_slice(16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        send_bits(fa, 0, CFG_LEN, 0);
        run_cycles(30);

        // Asynchronous reset in RUN, sampled before any clock edge.
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);

        // Toggle flop through feedback.
        fa = {rand_slice(), mk_slice(16'h00FF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
        send_bits(fa, 0, CFG_LEN, 0);
        run_cycles(20);

        // SR/CE behaviour with CE in use and set value 1.
        fa = {rand_slice(), mk_slice(TBL'($urandom), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)};
        send_bits(fa, 0, CFG_LEN, 0);
        run_cycles(30);

        // Pause after 20 bits, then finish the frame.
        fa = {rand_slice(), rand_slice()};
        send_bits(fa, 0, 20, 0);
        run_cycles(10);
        send_bits(fa, 20, CFG_LEN, 0);
        run_cycles(10);

        // Abort a partial load with reset, then load a fresh frame.
        fa = {rand_slice(), rand_slice()};
        fb = {rand_slice(), rand_slice()};
        send_bits(fa, 0, 30, 0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        send_bits(fb, 0, CFG_LEN, 0);
        run_cycles(10);

        // Daisy chain: two frames back to back, first one emerges on CFG_DOUT.
        fa = {rand_slice(), rand_slice()};
        fb = {rand_slice(), rand_slice()};
        send_bits(fa, 0, CFG_LEN, 0);
        send_bits(fb, 0, CFG_LEN, 0);
        run_cycles(10);

        // Random reconfiguration from RUN with random pauses.
        for (int f = 0; f < 8; f++) begin
            fa = {rand_slice(), rand_slice()};
            send_bits(fa, 0, CFG_LEN, 20);
            run_cycles(25);
        end

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge K);
        #1;
        if (exp_q.size() > 0) begin
            bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
